// File: rtl/toggle_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_rx_decoder
//  Purpose  : Decodes a toggle-encoded serial line into LSB-first words.
//             Optional trailing even-parity bit when TOGGLE_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module toggle_rx_decoder #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             line_in,
    input  logic             sample_en,
    input  logic             align,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun,
    output logic             parity_err
);

    logic             r_prev_line;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_parity_err;

    logic             w_bit;
    logic             w_last;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word;
    logic             w_par_bad;

`ifdef TOGGLE_PARITY_EN
    // The parity sample closes the frame; data bits are already in r_shift.
    localparam int c_LAST = WIDTH;
    assign w_word    = r_shift;
    assign w_par_bad = w_bit ^ (^r_shift);
`else
    localparam int c_LAST = WIDTH - 1;
    assign w_word    = w_shift_next;
    assign w_par_bad = 1'b0;
`endif

    always_comb begin
        w_bit        = line_in ^ r_prev_line;
        w_shift_next = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_bit_cnt == CW'(i)) begin
                w_shift_next[i] = w_bit;
            end
        end
        w_last = (r_bit_cnt == CW'(c_LAST));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_prev_line  <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end

            if (align) begin
                r_bit_cnt   <= '0;
                r_shift     <= '0;
                r_prev_line <= line_in;
            end else if (sample_en) begin
                r_prev_line <= line_in;
                if (w_last) begin
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                    if (w_par_bad) begin
                        r_parity_err <= 1'b1;
                    end
                    // A finished word may replace one being consumed this same cycle.
                    if (!r_valid || out_ready) begin
                        r_data  <= w_word;
                        r_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                    r_shift   <= w_shift_next;
                end
            end
        end
    end

    assign data_out   = r_data;
    assign out_valid  = r_valid;
    assign bit_cnt    = r_bit_cnt;
    assign overrun    = r_overrun;
    assign parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_toggle_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_rx_decoder
//  Purpose  : Scoreboard bench for toggle_rx_decoder (WIDTH = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_rx_decoder;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             clr;
    logic             line_in;
    logic             sample_en;
    logic             align;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    logic             parity_err;

    logic             line;
    logic [WIDTH-1:0] sb_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    toggle_rx_decoder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .line_in   (line_in),
        .sample_en (sample_en),
        .align     (align),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every accepted handshake must match the oldest word the bench expects.
    always @(negedge clk) begin
        if (!clr && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_word", {24'd0, data_out}, 32'hFFFF_FFFF);
            end else begin
                check("word", {24'd0, data_out}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic send_bit(input logic b);
        line      = line ^ b;
        line_in   = line;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit push, input bit par_flip);
        if (push) sb_q.push_back(w);
        for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
`ifdef TOGGLE_PARITY_EN
        send_bit((^w) ^ par_flip);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr     = 1'b0;
        line    = 1'b0;
        line_in = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        clr = 1'b1; line = 1'b0; line_in = 1'b0; sample_en = 1'b0;
        align = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", {24'd0, data_out}, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'h0);
        check("rst_bitcnt", {28'd0, bit_cnt}, 32'h0);
        check("rst_overrun", {31'd0, overrun}, 32'h0);
        check("rst_parity", {31'd0, parity_err}, 32'h0);
        clr = 1'b0;
        idle(1);

        // Single word: levels 1,1,0,0,0,1,1,0 encode A5.
        send_word(8'hA5, 1'b1, 1'b0);
        check("t1_valid", {31'd0, out_valid}, 32'h1);
        check("t1_data", {24'd0, data_out}, 32'hA5);
        check("t1_bitcnt", {28'd0, bit_cnt}, 32'h0);

        // Back-to-back words with continuous sampling.
        send_word(8'hA5, 1'b1, 1'b0);
        send_word(8'h3C, 1'b1, 1'b0);
        check("t2_data", {24'd0, data_out}, 32'h3C);
        check("t2_overrun", {31'd0, overrun}, 32'h0);
        idle(1);

        // Stalled consumer: second word is dropped.
        out_ready = 1'b0;
        send_word(8'hA5, 1'b1, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        check("t3_data_held", {24'd0, data_out}, 32'hA5);
        check("t3_valid", {31'd0, out_valid}, 32'h1);
        check("t3_overrun", {31'd0, overrun}, 32'h1);
        idle(2);
        check("t3_still_held", {24'd0, data_out}, 32'hA5);
        out_ready = 1'b1;
        idle(1);
        check("t3_valid_drop", {31'd0, out_valid}, 32'h0);
        check("t3_data_kept", {24'd0, data_out}, 32'hA5);

        // Re-alignment mid-word; align wins over a simultaneous sample.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("t4_bitcnt3", {28'd0, bit_cnt}, 32'h3);
        line = 1'b1; line_in = 1'b1; align = 1'b1; sample_en = 1'b1;
        @(posedge clk); #1;
        align = 1'b0; sample_en = 1'b0;
        check("t4_bitcnt0", {28'd0, bit_cnt}, 32'h0);
        check("t4_overrun_kept", {31'd0, overrun}, 32'h1);
        send_word(8'h01, 1'b1, 1'b0);
        check("t4_data", {24'd0, data_out}, 32'h01);
        idle(1);

        // Clear mid-word with a pending word.
        out_ready = 1'b0;
        send_word(8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        check("t5_bitcnt5", {28'd0, bit_cnt}, 32'h5);
        do_clr();
        check("t5_data", {24'd0, data_out}, 32'h0);
        check("t5_valid", {31'd0, out_valid}, 32'h0);
        check("t5_bitcnt", {28'd0, bit_cnt}, 32'h0);
        check("t5_overrun", {31'd0, overrun}, 32'h0);
        check("t5_parity", {31'd0, parity_err}, 32'h0);
        out_ready = 1'b1;
        send_word(8'hA5, 1'b1, 1'b0);
        check("t5_fresh", {24'd0, data_out}, 32'hA5);
        idle(1);

`ifdef TOGGLE_PARITY_EN
        send_word(8'hA5, 1'b1, 1'b0);
        check("t6_par_ok", {31'd0, parity_err}, 32'h0);
        idle(1);
        send_word(8'hA5, 1'b1, 1'b1);
        check("t6_par_bad", {31'd0, parity_err}, 32'h1);
        check("t6_data", {24'd0, data_out}, 32'hA5);
        idle(1);
`else
        check("t6_par_tied", {31'd0, parity_err}, 32'h0);
`endif

        idle(2);
        check("drain", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
